// File: rtl/mem_access_pkg.sv
// Shared encodings for the RAM_B load/store access unit.
package mem_access_pkg;

    localparam int DEPTH_DEF = 128;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        ERR  = 3'd4
    } state_t;

    // Illegal sizes are reported through the same path as misaligned ones.
    function automatic logic is_misaligned(size_t size, logic [1:0] lane);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = lane[0];
            SZ_WORD: is_misaligned = (lane != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ram_b_access_ctrl_if.sv
// CPU-side request/response bus of the RAM_B access unit.
interface ram_b_access_ctrl_if;
    // A request transfers on a clock edge where req_valid and req_ready are both
    // high; req_* are captured on that edge only. resp_* are valid only while
    // resp_valid is high, a one-cycle pulse with no back-pressure.
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

// File: rtl/ram_b_lane.sv
// Byte-lane helpers: sub-word store merge and load extraction with extension.
module ram_b_lane
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    input  size_t       size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    output logic [31:0] merged,
    output logic [31:0] extracted
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        merged    = word;
        extracted = word;
        byte_v    = word[{lane, 3'b000} +: 8];
        half_v    = word[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: begin
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
                extracted = is_unsigned ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                merged[{lane[1], 4'b0000} +: 16] = wdata;
                extracted = is_unsigned ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/ram_b_access_ctrl.sv
// Load/store access unit in front of RAM_B: sub-word RMW stores, extending loads,
// alignment and range checks. All outputs are registered.
module ram_b_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ram_b_access_ctrl_if.slave   bus,
    output logic [ADDR_W-1:0]    ram_addra,
    output logic [DATA_W-1:0]    ram_dina,
    output logic                 ram_wea,
    input  logic [47:0]          ram_douta,
    output state_t               dbg_state
);
    state_t              state, state_n;
    logic                req_ready_q, req_ready_n;
    logic                resp_valid_q, resp_valid_n;
    logic                resp_err_q, resp_err_n;
    logic [31:0]         resp_rdata_q, resp_rdata_n;
    logic                ram_wea_n;
    logic [ADDR_W-1:0]   ram_addra_n;
    logic [DATA_W-1:0]   ram_dina_n;

    logic                lat_we, lat_uns;
    size_t               lat_size;
    logic [1:0]          lat_lane;
    logic [15:0]         lat_wdata;

    logic [ADDR_W-1:0]   idx;
    size_t               req_size;
    logic                req_bad, accept;
    logic [31:0]         merged, extracted;
    logic                unused_bits;

    assign idx         = bus.req_addr[ADDR_W+1:2];
    assign req_size    = size_t'(bus.req_size);
    assign req_bad     = is_misaligned(req_size, bus.req_addr[1:0]) || (idx >= ADDR_W'(DEPTH));
    assign accept      = bus.req_valid && (state == IDLE);
    // Upper address bits and RAM read bits [47:32] carry no information here.
    assign unused_bits = ^{bus.req_addr[31:ADDR_W+2], ram_douta[47:32]};

    ram_b_lane u_lane (
        .word        (ram_douta[31:0]),
        .wdata       (lat_wdata),
        .size        (lat_size),
        .lane        (lat_lane),
        .is_unsigned (lat_uns),
        .merged      (merged),
        .extracted   (extracted)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            ram_wea      <= 1'b0;
            ram_addra    <= '0;
            ram_dina     <= '0;
            lat_we       <= 1'b0;
            lat_uns      <= 1'b0;
            lat_size     <= SZ_BYTE;
            lat_lane     <= '0;
            lat_wdata    <= '0;
        end else begin
            state        <= state_n;
            req_ready_q  <= req_ready_n;
            resp_valid_q <= resp_valid_n;
            resp_err_q   <= resp_err_n;
            resp_rdata_q <= resp_rdata_n;
            ram_wea      <= ram_wea_n;
            ram_addra    <= ram_addra_n;
            ram_dina     <= ram_dina_n;
            if (accept) begin
                lat_we    <= bus.req_we;
                lat_uns   <= bus.req_unsigned;
                lat_size  <= req_size;
                lat_lane  <= bus.req_addr[1:0];
                lat_wdata <= bus.req_wdata[15:0];
            end
        end
    end

    always_comb begin
        state_n      = state;
        resp_valid_n = 1'b0;
        resp_err_n   = 1'b0;
        resp_rdata_n = '0;
        ram_wea_n    = 1'b0;
        ram_addra_n  = ram_addra;
        ram_dina_n   = ram_dina;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_bad) begin
                        state_n = ERR;
                    end else begin
                        ram_addra_n = idx;
                        // Full-word stores need no read, so they skip straight to WR.
                        if (bus.req_we && req_size == SZ_WORD) begin
                            state_n    = WR;
                            ram_wea_n  = 1'b1;
                            ram_dina_n = bus.req_wdata;
                        end else begin
                            state_n = RD;
                        end
                    end
                end
            end
            RD:   state_n = WAIT;
            WAIT: begin
                if (lat_we) begin
                    state_n    = WR;
                    ram_wea_n  = 1'b1;
                    ram_dina_n = merged;
                end else begin
                    state_n      = IDLE;
                    resp_valid_n = 1'b1;
                    resp_rdata_n = extracted;
                end
            end
            WR: begin
                state_n      = IDLE;
                resp_valid_n = 1'b1;
            end
            ERR: begin
                state_n      = IDLE;
                resp_valid_n = 1'b1;
                resp_err_n   = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        req_ready_n = (state_n == IDLE);
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign dbg_state      = state;
endmodule

// File: tb/tb_ram_b_access_ctrl.sv
// Scoreboard bench for ram_b_access_ctrl with a behavioural RAM_B and reference memory.
module tb_ram_b_access_ctrl;
    import mem_access_pkg::*;

    localparam int ADDR_W = 20;
    localparam int DEPTH  = 128;
    localparam int CLK_P  = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_load = 1'b1;
    always #(CLK_P/2) clk = ~clk;

    ram_b_access_ctrl_if bus();
    logic [ADDR_W-1:0] ram_addra;
    logic [31:0]       ram_dina;
    logic              ram_wea;
    logic [47:0]       ram_douta;
    state_t            dbg_state;

    ram_b_access_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .ram_addra (ram_addra),
        .ram_dina  (ram_dina),
        .ram_wea   (ram_wea),
        .ram_douta (ram_douta),
        .dbg_state (dbg_state)
    );

    // Behavioural RAM_B: synchronous read, one-cycle latency, high-Z while writing.
    logic [31:0] ram_mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= ref_mem[i];
            ram_douta <= '0;
        end else if (ram_wea) begin
            if (int'(ram_addra) < DEPTH) ram_mem[ram_addra] <= ram_dina;
            ram_douta <= 'z;
        end else begin
            ram_douta <= {16'hC3C3, (int'(ram_addra) < DEPTH) ? ram_mem[ram_addra] : 32'hBAD0BAD0};
        end
    end

    // ---------------- scoreboard ----------------
    logic [64:0] exp_q[$];   // {err, rdata, expected response cycle}
    logic [51:0] wr_q[$];    // {word index, write data}
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned nbytes(input logic [1:0] sz);
        return 32'd1 << sz;
    endfunction

    function automatic int unsigned word_index(input logic [31:0] addr);
        return (addr >> 2) & 32'h000F_FFFF;
    endfunction

    function automatic bit is_err(input logic [31:0] addr, input logic [1:0] sz);
        if (sz == 2'b11) return 1'b1;
        if ((addr % nbytes(sz)) != 0) return 1'b1;
        return word_index(addr) >= DEPTH;
    endfunction

    function automatic logic [31:0] load_value(input logic [31:0] word, input logic [31:0] addr,
                                               input logic [1:0] sz, input bit uns);
        int unsigned bits, v;
        if (sz == 2'b10) return word;
        bits = 8 * nbytes(sz);
        v = (word >> (8 * (addr % 4))) & ((32'd1 << bits) - 1);
        if (!uns && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
        return v;
    endfunction

    function automatic logic [31:0] store_value(input logic [31:0] old, input logic [31:0] addr,
                                                input logic [1:0] sz, input logic [31:0] wdata);
        int unsigned bits, sh, mask;
        if (sz == 2'b10) return wdata;
        bits = 8 * nbytes(sz);
        sh   = 8 * (addr % 4);
        mask = ((32'd1 << bits) - 1) << sh;
        return (old & ~mask) | ((wdata << sh) & mask);
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.resp_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got resp_valid=1 expected none at %0t", $time);
                end else begin
                    logic [64:0] e;
                    e = exp_q.pop_front();
                    check("resp_err", 64'(bus.resp_err), 64'(e[64]));
                    check("resp_rdata", 64'(bus.resp_rdata), 64'(e[63:32]));
                    check("resp_cycle", 64'($time / CLK_P), 64'(e[31:0]));
                end
            end
            if (ram_wea) begin
                check("wea_in_wr", 64'(dbg_state), 64'(WR));
                if (wr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_wea: got ram_wea=1 addr %h expected none at %0t", ram_addra, $time);
                end else begin
                    logic [51:0] w;
                    w = wr_q.pop_front();
                    check("ram_addra", 64'(ram_addra), 64'(w[51:32]));
                    check("ram_dina", 64'(ram_dina), 64'(w[31:0]));
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic wait_ready();
        int n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got req_ready=0 expected 1 within 50 cycles");
        end
    endtask

    task automatic issue(input bit we, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit track);
        int unsigned cyc, idx;
        logic [31:0] nw;
        wait_ready();
        cyc = 32'($time / CLK_P);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        idx = word_index(addr);
        if (is_err(addr, sz)) begin
            exp_q.push_back({1'b1, 32'h0, cyc + 32'd2});
        end else if (we) begin
            nw = store_value(ref_mem[idx], addr, sz, wdata);
            if (track) ref_mem[idx] = nw;
            wr_q.push_back({idx[19:0], nw});
            exp_q.push_back({1'b0, 32'h0, cyc + ((sz == 2'b10) ? 32'd2 : 32'd4)});
        end else begin
            exp_q.push_back({1'b0, load_value(ref_mem[idx], addr, sz, uns), cyc + 32'd3});
        end
        @(negedge clk);
        // Scramble the bus after acceptance; the DUT must use its latched copy.
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'($urandom_range(0, 1));
        bus.req_size     = 2'($urandom_range(0, 3));
        bus.req_unsigned = 1'($urandom_range(0, 1));
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [31:0] a;
        logic [1:0]  sz;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;

        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_err", 64'(bus.resp_err), 64'd0);
        check("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
        check("rst_ram_wea", 64'(ram_wea), 64'd0);
        check("rst_ram_addra", 64'(ram_addra), 64'd0);
        check("rst_ram_dina", 64'(ram_dina), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        mem_load = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Word store then load, byte RMW store.
        issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 1);
        issue(0, 2'b10, 0, 32'h10, 32'h0, 1);
        issue(1, 2'b10, 0, 32'h10, 32'h11223344, 1);
        issue(1, 2'b00, 0, 32'h11, 32'h0000005A, 1);
        issue(0, 2'b10, 0, 32'h10, 32'h0, 1);
        // Extension cases on 0x8000F0FF.
        issue(1, 2'b10, 0, 32'h40, 32'h8000F0FF, 1);
        issue(0, 2'b00, 0, 32'h40, 32'h0, 1);
        issue(0, 2'b00, 1, 32'h40, 32'h0, 1);
        issue(0, 2'b01, 0, 32'h42, 32'h0, 1);
        issue(0, 2'b01, 1, 32'h42, 32'h0, 1);
        issue(0, 2'b00, 0, 32'h43, 32'h0, 1);
        issue(1, 2'b01, 0, 32'h42, 32'hABCD1234, 1);
        issue(0, 2'b10, 0, 32'h40, 32'h0, 1);
        // Misaligned and illegal.
        issue(0, 2'b10, 0, 32'h13, 32'h0, 1);
        issue(1, 2'b01, 0, 32'h21, 32'h12345678, 1);
        issue(0, 2'b11, 0, 32'h20, 32'h0, 1);
        issue(1, 2'b11, 0, 32'h20, 32'hFFFFFFFF, 1);
        // Out of range, then an unaffected load.
        issue(1, 2'b00, 0, 32'h200, 32'h000000EE, 1);
        issue(0, 2'b10, 0, 32'h1FC, 32'h0, 1);
        issue(0, 2'b10, 0, 32'h0, 32'h0, 1);

        // Reset during WAIT of a byte store abandons it.
        issue(1, 2'b00, 0, 32'h25, 32'h000000A7, 0);
        n = 0;
        while (dbg_state != WAIT && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("mid_rst_reach_wait", 64'(dbg_state), 64'(WAIT));
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_state", 64'(dbg_state), 64'(IDLE));
        check("mid_rst_wea", 64'(ram_wea), 64'd0);
        check("mid_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        exp_q.delete();
        wr_q.delete();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_mem_word", 64'(ram_mem[9]), 64'(ref_mem[9]));
        issue(0, 2'b10, 0, 32'h24, 32'h0, 1);

        // Randomised traffic.
        for (int i = 0; i < 80; i++) begin
            a = ($urandom_range(0, 9) == 0) ? 32'h200 + $urandom_range(0, 32'h1FF)
                                            : $urandom_range(0, 32'h1FF);
            if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(0, 1023)) << 22);
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~(nbytes(sz) - 1);
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1);
        end

        n = 0;
        while ((exp_q.size() > 0 || wr_q.size() > 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_exp_q", 64'(exp_q.size()), 64'd0);
        check("drain_wr_q", 64'(wr_q.size()), 64'd0);
        for (int i = 0; i < DEPTH; i++) check("final_mem", 64'(ram_mem[i]), 64'(ref_mem[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(CLK_P * 20000);
        $display("FAIL watchdog: got no completion expected finish within 20000 cycles");
        $fatal(1, "watchdog expired");
    end
endmodule
